cram_sbr_stack: RTL and testbench

Parametrised CRAM subroutine CALL/RETURN stack for the microsequencer address path.
- Pushes a return address on CALL or on a force-1777 trap; pops on RET.
- Presents the top entry to the dispatch mux as sbrRet.
- Replaces the fixed 16-entry hardwired-sequence stack with a circular buffer of configurable depth and width.
- Adds overflow/underflow status and an indexed diagnostic readback for the EBUS diagnostic path.

---
 rtl/cra_pkg.sv | 15 +
 rtl/sbr_stack_mem.sv | 34 +++
 rtl/cram_sbr_stack.sv | 167 ++++++++++++++++
 tb/tb_cram_sbr_stack.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cra_pkg.sv
// Shared CRAM microsequencer types and default sizes.
package cra_pkg;

    localparam int unsigned CRAM_ADR_W        = 11;
    localparam int unsigned SBR_DEPTH_DEFAULT = 16;

    // Stack operation decoded each cycle from call/force1777/ret.
    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        PUSH    = 2'd1,
        POP     = 2'd2,
        REPLACE = 2'd3
    } stack_op_t;

endpackage : cra_pkg

// File: rtl/sbr_stack_mem.sv
// Subroutine stack register file: one write port, combinational top and
// diagnostic read ports. Contents are deliberately not reset.
module sbr_stack_mem #(
    parameter int unsigned DATA_W = 11,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = 4,
    parameter int unsigned DIAG_W = DATA_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_top_i,
    output logic [DATA_W-1:0] rdata_top_o,
    input  logic [AW-1:0]     raddr_diag_i,
    output logic [DIAG_W-1:0] rdata_diag_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] diag_entry;

    // Single write port, written on push/replace.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_top_o  = mem_q[raddr_top_i];
    assign diag_entry   = mem_q[raddr_diag_i];
    // Diagnostic port carries address bits only; any parity bit is dropped.
    assign rdata_diag_o = diag_entry[DIAG_W-1:0];

endmodule : sbr_stack_mem

// File: rtl/cram_sbr_stack.sv
// CRAM subroutine CALL/RETURN stack: circular buffer of return addresses
// with overflow/underflow status and indexed diagnostic readback.
// Optional feature macro: CRA_STACK_PARITY_EN (adds per-entry odd parity
// and the parityErr output).
module cram_sbr_stack
    import cra_pkg::*;
#(
    parameter int unsigned ADR_W = CRAM_ADR_W,
    parameter int unsigned DEPTH = SBR_DEPTH_DEFAULT,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             call,
    input  logic             ret,
    input  logic             force1777,
    input  logic [ADR_W-1:0] retAdrIn,
    input  logic             clrErr,
    input  logic [PTR_W-1:0] diagIdx,
    output logic [ADR_W-1:0] sbrRet,
    output logic [PTR_W:0]   count,
`ifdef CRA_STACK_PARITY_EN
    output logic             parityErr,
`endif
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow,
    output logic [ADR_W-1:0] diagData
);

`ifdef CRA_STACK_PARITY_EN
    localparam int unsigned ENTRY_W = ADR_W + 1;
`else
    localparam int unsigned ENTRY_W = ADR_W;
`endif
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

    // Reject unsupported geometries at elaboration.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("cram_sbr_stack: DEPTH must be a power of two >= 2");
    end
    if (PTR_W != $clog2(DEPTH)) begin : g_bad_ptr_w
        $error("cram_sbr_stack: PTR_W is derived from DEPTH and must not be overridden");
    end

    logic [PTR_W-1:0]   top_q, top_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    stack_op_t          op;
    logic               push, pop, grow;
    logic               ovf_set, unf_set;
    logic               we;
    logic [PTR_W-1:0]   waddr;
    logic [ENTRY_W-1:0] wdata;
    logic [ENTRY_W-1:0] top_rd;
    logic [ADR_W-1:0]   diag_rd;
    logic [PTR_W-1:0]   diag_addr;
    logic               diag_hit;

    assign push = call | force1777;
    assign pop  = ret & ~force1777;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_CNT);

`ifdef CRA_STACK_PARITY_EN
    assign wdata = {~^retAdrIn, retAdrIn};
`else
    assign wdata = retAdrIn;
`endif

    // Decode the operation for this cycle.
    always_comb begin
        op = HOLD;
        case ({push, pop})
            2'b10:   op = PUSH;
            2'b01:   op = POP;
            2'b11:   op = REPLACE;
            default: op = HOLD;
        endcase
    end

    // Next-state for pointer, count and sticky flags plus write control.
    always_comb begin
        top_d   = top_q;
        count_d = count_q;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        we      = 1'b0;
        waddr   = top_q;
        // Replace on an empty stack has nothing to overwrite, so it pushes.
        grow    = (op == PUSH) || ((op == REPLACE) && empty);

        if (grow) begin
            top_d = top_q + PTR_W'(1);
            we    = 1'b1;
            waddr = top_q + PTR_W'(1);
            if (full) begin
                ovf_set = 1'b1;
            end else begin
                count_d = count_q + (PTR_W+1)'(1);
            end
        end else if (op == REPLACE) begin
            we    = 1'b1;
            waddr = top_q;
        end else if (op == POP) begin
            if (empty) begin
                unf_set = 1'b1;
            end else begin
                top_d   = top_q - PTR_W'(1);
                count_d = count_q - (PTR_W+1)'(1);
            end
        end

        // A flag-setting event beats a same-cycle clear.
        ovf_d = ovf_set | (ovf_q & ~clrErr);
        unf_d = unf_set | (unf_q & ~clrErr);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign diag_addr = top_q - diagIdx;
    assign diag_hit  = ({1'b0, diagIdx} < count_q);

    sbr_stack_mem #(
        .DATA_W (ENTRY_W),
        .DEPTH  (DEPTH),
        .AW     (PTR_W),
        .DIAG_W (ADR_W)
    ) u_mem (
        .clk_i        (clk),
        .we_i         (we),
        .waddr_i      (waddr),
        .wdata_i      (wdata),
        .raddr_top_i  (top_q),
        .rdata_top_o  (top_rd),
        .raddr_diag_i (diag_addr),
        .rdata_diag_o (diag_rd)
    );

    assign sbrRet    = empty ? '0 : top_rd[ADR_W-1:0];
    assign diagData  = diag_hit ? diag_rd : '0;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

`ifdef CRA_STACK_PARITY_EN
    // Stored odd parity: a valid entry always has an odd number of ones.
    assign parityErr = ~empty & ~(^top_rd);
`endif

endmodule : cram_sbr_stack

// File: tb/tb_cram_sbr_stack.sv
// Directed self-checking bench for cram_sbr_stack (default ADR_W=11, DEPTH=16).
module tb_cram_sbr_stack;

    localparam int unsigned ADR_W = 11;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned PTR_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             call;
    logic             ret;
    logic             force1777;
    logic [ADR_W-1:0] retAdrIn;
    logic             clrErr;
    logic [PTR_W-1:0] diagIdx;
    logic [ADR_W-1:0] sbrRet;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;
    logic [ADR_W-1:0] diagData;
`ifdef CRA_STACK_PARITY_EN
    logic             parityErr;
    logic [ADR_W:0]   corrupt;
`endif

    int compared   = 0;
    int mismatched = 0;

    cram_sbr_stack #(
        .ADR_W (ADR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .call      (call),
        .ret       (ret),
        .force1777 (force1777),
        .retAdrIn  (retAdrIn),
        .clrErr    (clrErr),
        .diagIdx   (diagIdx),
        .sbrRet    (sbrRet),
        .count     (count),
`ifdef CRA_STACK_PARITY_EN
        .parityErr (parityErr),
`endif
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow),
        .diagData  (diagData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs at a falling edge; return at the next falling edge.
    task automatic cyc(input logic c, input logic r, input logic f,
                       input logic [ADR_W-1:0] adr, input logic clr);
        call = c; ret = r; force1777 = f; retAdrIn = adr; clrErr = clr;
        @(negedge clk);
        call = 1'b0; ret = 1'b0; force1777 = 1'b0; retAdrIn = '0; clrErr = 1'b0;
        #1;
    endtask

    task automatic do_push(input logic [ADR_W-1:0] adr);
        cyc(1'b1, 1'b0, 1'b0, adr, 1'b0);
    endtask

    task automatic do_pop();
        cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; call = 1'b0; ret = 1'b0; force1777 = 1'b0;
        retAdrIn = '0; clrErr = 1'b0; diagIdx = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_sbrRet",    32'(sbrRet),    32'd0);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_empty",     32'(empty),     32'd1);
        chk("rst_full",      32'(full),      32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_diagData",  32'(diagData),  32'd0);
        reset = 1'b0;
        @(negedge clk); #1;

        // Basic push/pop ordering.
        do_push(11'o1234);
        do_push(11'o0567);
        chk("pp_sbrRet2", 32'(sbrRet), 32'o0567);
        chk("pp_count2",  32'(count),  32'd2);
        do_pop();
        chk("pp_sbrRet1", 32'(sbrRet), 32'o1234);
        chk("pp_count1",  32'(count),  32'd1);
        do_pop();
        chk("pp_empty",   32'(empty),  32'd1);
        chk("pp_sbrRet0", 32'(sbrRet), 32'd0);

        // Overflow: 17 pushes into a 16-deep stack drop value 1.
        for (int v = 1; v <= 17; v++) do_push(ADR_W'(v));
        chk("ovf_full",     32'(full),     32'd1);
        chk("ovf_overflow", 32'(overflow), 32'd1);
        chk("ovf_count",    32'(count),    32'd16);
        chk("ovf_top",      32'(sbrRet),   32'd17);
        diagIdx = 4'd15; #1;
        chk("ovf_diag15",   32'(diagData), 32'd2);
        diagIdx = 4'd0; #1;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("ovf_pop%0d", k), 32'(sbrRet), 32'(17 - k));
            do_pop();
            if (k == 0) chk("ovf_notfull", 32'(full), 32'd0);
        end
        chk("ovf_empty",  32'(empty),  32'd1);
        chk("ovf_ret0",   32'(sbrRet), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("ovf_clr",    32'(overflow), 32'd0);

        // Underflow and clear priority.
        do_pop();
        chk("unf_set",   32'(underflow), 32'd1);
        chk("unf_count", 32'(count),     32'd0);
        cyc(1'b0, 1'b1, 1'b0, '0, 1'b1);
        chk("unf_win",   32'(underflow), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("unf_clr",   32'(underflow), 32'd0);

        // Replace on an empty stack behaves as a push.
        cyc(1'b1, 1'b1, 1'b0, 11'o0042, 1'b0);
        chk("repe_count", 32'(count),  32'd1);
        chk("repe_top",   32'(sbrRet), 32'o0042);
        chk("repe_unf",   32'(underflow), 32'd0);
        do_pop();

        // Replace vs. trap push on a 3-deep stack.
        do_push(11'o0100);
        do_push(11'o0200);
        do_push(11'o0300);
        cyc(1'b1, 1'b1, 1'b0, 11'o0777, 1'b0);
        chk("rep_top",   32'(sbrRet), 32'o0777);
        chk("rep_count", 32'(count),  32'd3);
        diagIdx = 4'd1; #1;
        chk("rep_diag1", 32'(diagData), 32'o0200);
        cyc(1'b1, 1'b1, 1'b1, 11'o0777, 1'b0);
        chk("trap_count", 32'(count),  32'd4);
        chk("trap_top",   32'(sbrRet), 32'o0777);
        chk("trap_diag1", 32'(diagData), 32'o0777);
        cyc(1'b0, 1'b1, 1'b1, 11'o1777, 1'b0);
        chk("trapret_count", 32'(count),  32'd5);
        chk("trapret_top",   32'(sbrRet), 32'o1777);

        // Diagnostic readback.
        diagIdx = 4'd0;
        do_reset();
        chk("rst2_count", 32'(count), 32'd0);
        do_push(11'o0010);
        do_push(11'o0020);
        do_push(11'o0030);
        diagIdx = 4'd0; #1;
        chk("diag0", 32'(diagData), 32'o0030);
        diagIdx = 4'd1; #1;
        chk("diag1", 32'(diagData), 32'o0020);
        diagIdx = 4'd2; #1;
        chk("diag2", 32'(diagData), 32'o0010);
        diagIdx = 4'd3; #1;
        chk("diag3", 32'(diagData), 32'd0);
        diagIdx = 4'd0;

        // Asynchronous reset takes effect before any clock edge.
        #2 reset = 1'b1;
        #1;
        chk("arst_count",  32'(count),  32'd0);
        chk("arst_sbrRet", 32'(sbrRet), 32'd0);
        chk("arst_diag",   32'(diagData), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;

`ifdef CRA_STACK_PARITY_EN
        // Parity: corrupt the top entry, then pop back to an intact one.
        do_push(11'o0005);
        do_push(11'o0006);
        chk("par_clean", 32'(parityErr), 32'd0);
        corrupt = dut.u_mem.mem_q[dut.top_q];
        corrupt[0] = ~corrupt[0];
        dut.u_mem.mem_q[dut.top_q] = corrupt;
        #1;
        chk("par_err", 32'(parityErr), 32'd1);
        do_pop();
        chk("par_ok",  32'(parityErr), 32'd0);
        chk("par_top", 32'(sbrRet),    32'o0005);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_cram_sbr_stack
